// File: rtl/spi_rx_pkg.sv
// Shared types and default geometry for the camera-link pixel receiver.
package spi_rx_pkg;

  typedef enum logic [1:0] {IDLE, RECV, HOLD} rx_state_t;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_LINES      = 4;
  localparam int DEFAULT_H_PIXELS   = 160;
  localparam int DEFAULT_V_PIXELS   = 90;

endpackage

// File: rtl/pin_synchronizer.sv
// Two-flop synchronizer for asynchronous pins, with a per-bit reset value.
module pin_synchronizer #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/spi_pixel_receiver.sv
// Rebuilds pixels from the 4-line camera link and tags each with its
// (hcount, vcount) position in the decimated frame.
module spi_pixel_receiver
  import spi_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int LINES      = DEFAULT_LINES,
  parameter int H_PIXELS   = DEFAULT_H_PIXELS,
  parameter int V_PIXELS   = DEFAULT_V_PIXELS
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [LINES-1:0]            chip_data_in,
  input  logic                        chip_clk_in,
  input  logic                        chip_sel_in,
  input  logic                        frame_end_in,
  output logic [DATA_WIDTH-1:0]       pixel_out,
  output logic                        valid_out,
  output logic [$clog2(H_PIXELS)-1:0] hcount_out,
  output logic [$clog2(V_PIXELS)-1:0] vcount_out,
  output logic                        frame_done_out,
  output logic                        sync_err_out
);

  localparam int BEATS = DATA_WIDTH / LINES;
  localparam int HW    = $clog2(H_PIXELS);
  localparam int VW    = $clog2(V_PIXELS);
  localparam int BW    = $clog2(BEATS + 1);

  logic [2:0]            w_ctl_sync;
  logic [LINES-1:0]      w_data_sync;
  logic [2:0]            r_ctl_prev;
  logic                  r_cs_fall, r_cs_rise, r_dclk_rise, r_fe_rise;
  logic [LINES-1:0]      r_data_p;
  rx_state_t             r_state, w_state_next;
  logic [BW-1:0]         r_beat_cnt;
  logic                  w_shift_en, w_emit, w_abort, w_hold_err;
  logic [DATA_WIDTH-1:0] w_shifted;
  logic [HW-1:0]         r_hcount;
  logic [VW-1:0]         r_vcount;
  logic                  r_last_at_end;
  logic                  w_at_end, w_end_ok;

  // Control bits {cs, dclk, frame_end}; cs idles high.
  pin_synchronizer #(.WIDTH(3), .RST_VAL(3'b100)) u_ctl_sync (
    .i_clk   (clk_in),
    .i_rst   (rst_in),
    .i_async ({chip_sel_in, chip_clk_in, frame_end_in}),
    .o_sync  (w_ctl_sync)
  );

  pin_synchronizer #(.WIDTH(LINES), .RST_VAL('0)) u_data_sync (
    .i_clk   (clk_in),
    .i_rst   (rst_in),
    .i_async (chip_data_in),
    .o_sync  (w_data_sync)
  );

  // Edge-detect stage: registered pulses, data delayed to stay aligned.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_ctl_prev  <= 3'b100;
      r_cs_fall   <= 1'b0;
      r_cs_rise   <= 1'b0;
      r_dclk_rise <= 1'b0;
      r_fe_rise   <= 1'b0;
    end else begin
      r_ctl_prev  <= w_ctl_sync;
      r_cs_fall   <= ~w_ctl_sync[2] &  r_ctl_prev[2];
      r_cs_rise   <=  w_ctl_sync[2] & ~r_ctl_prev[2];
      r_dclk_rise <=  w_ctl_sync[1] & ~r_ctl_prev[1];
      r_fe_rise   <=  w_ctl_sync[0] & ~r_ctl_prev[0];
    end
  end

  always_ff @(posedge clk_in) begin
    r_data_p <= w_data_sync;
  end

  if (BEATS > 1) begin : g_multi
    logic [DATA_WIDTH-LINES-1:0] r_shift;
    always_ff @(posedge clk_in) begin
      if (w_shift_en) r_shift <= w_shifted[DATA_WIDTH-LINES-1:0];
    end
    assign w_shifted = {r_shift, r_data_p};
  end else begin : g_single
    assign w_shifted = r_data_p;
  end

  always_comb begin
    w_state_next = r_state;
    w_shift_en   = 1'b0;
    w_emit       = 1'b0;
    w_abort      = 1'b0;
    w_hold_err   = 1'b0;
    case (r_state)
      IDLE: if (r_cs_fall) w_state_next = RECV;
      RECV: begin
        if (r_dclk_rise) begin
          w_shift_en = 1'b1;
          if (r_beat_cnt == BW'(BEATS - 1)) begin
            w_emit       = 1'b1;
            w_state_next = r_cs_rise ? IDLE : HOLD;
          end
        end
        if (r_cs_rise && !w_emit) begin
          w_abort      = 1'b1;
          w_state_next = IDLE;
        end
      end
      HOLD: begin
        w_hold_err = r_dclk_rise;
        if (r_cs_rise) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_at_end = (r_hcount == HW'(H_PIXELS - 1)) && (r_vcount == VW'(V_PIXELS - 1));
  // A pixel emitted alongside frame end counts as the frame's last pixel.
  assign w_end_ok = w_emit ? w_at_end : r_last_at_end;

  // Output stage: FSM state, counters, pixel beat, framing flags.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state        <= IDLE;
      r_beat_cnt     <= '0;
      r_hcount       <= '0;
      r_vcount       <= '0;
      r_last_at_end  <= 1'b0;
      pixel_out      <= '0;
      valid_out      <= 1'b0;
      hcount_out     <= '0;
      vcount_out     <= '0;
      frame_done_out <= 1'b0;
      sync_err_out   <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      valid_out      <= w_emit;
      frame_done_out <= r_fe_rise;
      if (w_state_next != RECV) r_beat_cnt <= '0;
      else if (w_shift_en)      r_beat_cnt <= r_beat_cnt + 1'b1;
      if (w_emit) begin
        pixel_out  <= w_shifted;
        hcount_out <= r_hcount;
        vcount_out <= r_vcount;
      end
      if (r_fe_rise) begin
        r_hcount      <= '0;
        r_vcount      <= '0;
        r_last_at_end <= 1'b0;
      end else if (w_emit) begin
        r_last_at_end <= w_at_end;
        if (r_hcount == HW'(H_PIXELS - 1)) begin
          r_hcount <= '0;
          r_vcount <= (r_vcount == VW'(V_PIXELS - 1)) ? '0 : r_vcount + 1'b1;
        end else begin
          r_hcount <= r_hcount + 1'b1;
        end
      end
      if (w_abort || w_hold_err || (r_fe_rise && !w_end_ok)) sync_err_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_pixel_receiver.sv
// Randomized scoreboard bench for spi_pixel_receiver.
module tb_spi_pixel_receiver;

  localparam int H  = 160;
  localparam int V  = 6;
  localparam int HW = $clog2(H);
  localparam int VW = $clog2(V);

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    data;
  logic          dclk, cs, fe;
  logic [7:0]    pixel_out;
  logic          valid_out;
  logic [HW-1:0] hcount_out;
  logic [VW-1:0] vcount_out;
  logic          frame_done_out;
  logic          sync_err_out;

  spi_pixel_receiver #(
    .DATA_WIDTH(8), .LINES(4), .H_PIXELS(H), .V_PIXELS(V)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .chip_data_in   (data),
    .chip_clk_in    (dclk),
    .chip_sel_in    (cs),
    .frame_end_in   (fe),
    .pixel_out      (pixel_out),
    .valid_out      (valid_out),
    .hcount_out     (hcount_out),
    .vcount_out     (vcount_out),
    .frame_done_out (frame_done_out),
    .sync_err_out   (sync_err_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pix;
    int h;
    int v;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   fe_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   m_n = 0;
  int   m_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_pixel(input logic [7:0] b);
    exp_t e;
    cs = 1'b0;
    tick(3);
    for (int k = 0; k < 2; k++) begin
      data = (k == 0) ? b[7:4] : b[3:0];
      tick(3);
      dclk = 1'b1;
      if (k == 1) begin
        e.pix = int'(b);
        e.h   = m_n % H;
        e.v   = (m_n / H) % V;
        e.cyc = cyc + 4;
        exp_q.push_back(e);
        m_n++;
      end
      tick(3);
      dclk = 1'b0;
      tick(1);
    end
    cs = 1'b1;
    tick(4);
  endtask

  task automatic send_frame_end();
    if (m_n == 0 || (m_n % (H * V)) != 0) m_err = 1;
    m_n = 0;
    fe = 1'b1;
    fe_q.push_back(cyc + 4);
    tick(3);
    fe = 1'b0;
    tick(4);
  endtask

  task automatic check_reset_outputs();
    chk("rst_pixel", int'(pixel_out), 0);
    chk("rst_valid", int'(valid_out), 0);
    chk("rst_hcount", int'(hcount_out), 0);
    chk("rst_vcount", int'(vcount_out), 0);
    chk("rst_frame_done", int'(frame_done_out), 0);
    chk("rst_sync_err", int'(sync_err_out), 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a beat.
  logic prev_valid = 1'b0;
  logic prev_done  = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    int   t;
    if (valid_out) begin
      chk("valid_pulse_width", int'(prev_valid), 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("pixel", int'(pixel_out), e.pix);
        chk("hcount", int'(hcount_out), e.h);
        chk("vcount", int'(vcount_out), e.v);
        chk("valid_latency_cycle", cyc, e.cyc);
      end
    end
    if (frame_done_out) begin
      chk("frame_done_pulse_width", int'(prev_done), 0);
      if (fe_q.size() == 0) begin
        chk("unexpected_frame_done", 1, 0);
      end else begin
        t = fe_q.pop_front();
        chk("frame_done_cycle", cyc, t);
      end
    end
    prev_valid = valid_out;
    prev_done  = frame_done_out;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cs = 1'b1; dclk = 1'b0; data = 4'h0; fe = 1'b0;
    tick(5);
    check_reset_outputs();
    rst = 1'b0;
    tick(5);

    send_pixel(8'hA5);
    tick(4);
    chk("err_after_single", int'(sync_err_out), m_err);

    // Aborted byte: one beat then cs rises; position is not consumed.
    cs = 1'b0; tick(3);
    data = 4'h9; tick(3);
    dclk = 1'b1; tick(3);
    dclk = 1'b0; tick(1);
    cs = 1'b1; tick(8);
    m_err = 1;
    chk("err_after_abort", int'(sync_err_out), m_err);
    send_pixel(8'h3C);

    // Reset in the middle of a byte.
    cs = 1'b0; tick(3);
    data = 4'hF; tick(3);
    dclk = 1'b1; tick(3);
    dclk = 1'b0;
    rst = 1'b1;
    tick(2);
    cs = 1'b1;
    tick(3);
    check_reset_outputs();
    rst = 1'b0;
    m_n = 0; m_err = 0;
    tick(4);
    send_pixel(8'hFF);
    tick(4);
    chk("err_after_reset", int'(sync_err_out), m_err);

    // Full frame from a clean start, covering the row wrap at 160/161.
    rst = 1'b1; tick(2); rst = 1'b0; tick(4);
    m_n = 0; m_err = 0;
    for (int i = 0; i < H * V; i++) send_pixel(8'($urandom_range(0, 255)));
    send_frame_end();
    tick(4);
    chk("err_after_full_frame", int'(sync_err_out), m_err);
    send_pixel(8'($urandom_range(0, 255)));

    // Short frame: 100 pixels then frame end.
    for (int i = 1; i < 100; i++) send_pixel(8'($urandom_range(0, 255)));
    send_frame_end();
    tick(4);
    chk("err_after_short_frame", int'(sync_err_out), m_err);
    send_pixel(8'($urandom_range(0, 255)));

    tick(10);
    chk("pixels_outstanding", exp_q.size(), 0);
    chk("frame_ends_outstanding", fe_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
